// File: rtl/lfsr_4_checker_if.sv
// lfsr_4_checker_if: bundles the bit stream and status signals of lfsr_4_checker.
//   master: drives bit_in, bit_valid, err_clr; observes the status outputs.
//   slave : the checker itself.
// Signals:
//   bit_in, bit_valid  received LFSR bit and its qualifier
//   err_clr            synchronous clear of err_count
//   locked             predictor is locked to the stream
//   err_pulse          one-cycle pulse per mismatch
//   stuck_zero         loaded window is 0000
//   err_count [7:0]    saturating mismatch count
//   pred_state [3:0]   predictor register (debug)
interface lfsr_4_checker_if;
  logic       bit_in;
  logic       bit_valid;
  logic       err_clr;
  logic       locked;
  logic       err_pulse;
  logic       stuck_zero;
  logic [7:0] err_count;
  logic [3:0] pred_state;

  modport master (
    output bit_in, bit_valid, err_clr,
    input  locked, err_pulse, stuck_zero, err_count, pred_state
  );

  modport slave (
    input  bit_in, bit_valid, err_clr,
    output locked, err_pulse, stuck_zero, err_count, pred_state
  );
endinterface

// File: rtl/lfsr_4_checker.sv
// lfsr_4_checker: self-synchronising checker for the 4-bit RNG LFSR stream
// (x[n] = x[n-4] ^ x[n-3], period 15). Fills a 4-bit window from the received
// bits, verifies LOCK_COUNT consecutive predictions, then flywheels on its own
// predictions while locked, dropping lock after ERR_LIMIT consecutive misses.
// Ports:
//   clk   clock
//   rst   asynchronous, active-low reset
//   bus   lfsr_4_checker_if.slave (bit_in/bit_valid/err_clr in, status out)
// Build option:
//   LFSR_CHK_ERRCNT_EN  when defined, err_count is an 8-bit saturating counter
//                       cleared by err_clr; otherwise err_count is tied to 0.
// All outputs are registered.
module lfsr_4_checker #(
  parameter int unsigned LOCK_COUNT = 8,  // 1..15
  parameter int unsigned ERR_LIMIT  = 2   // 1..7
) (
  input logic             clk,
  input logic             rst,
  lfsr_4_checker_if.slave bus
);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [2:0] ERR_LIM  = 3'(ERR_LIMIT);

  logic [1:0] state_q, state_d;
  logic [3:0] p_q, p_d;
  logic [2:0] fill_q, fill_d;
  logic [3:0] match_q, match_d;
  logic [2:0] miss_q, miss_d;
  logic       locked_q, locked_d;
  logic       stuck_q, stuck_d;
  logic       pulse_q, pulse_d;

  logic pred;
  logic hit;

  assign pred = p_q[3] ^ p_q[2];
  assign hit  = (bus.bit_in == pred);

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    fill_d   = fill_q;
    match_d  = match_q;
    miss_d   = miss_q;
    locked_d = locked_q;
    stuck_d  = stuck_q;
    pulse_d  = 1'b0;
    if (bus.bit_valid) begin
      unique case (state_q)
        ST_LOAD: begin
          p_d = {p_q[2:0], bus.bit_in};
          if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
          // Window complete on this bit (or already complete and re-tested).
          if (fill_q >= 3'd3) begin
            if (p_d == 4'b0000) begin
              stuck_d = 1'b1;
            end else begin
              stuck_d = 1'b0;
              state_d = ST_VERIFY;
              match_d = 4'd0;
            end
          end
        end
        ST_VERIFY: begin
          // Shift the received bit so a wrong window repairs itself.
          p_d = {p_q[2:0], bus.bit_in};
          if (hit) begin
            if (match_q + 4'd1 == LOCK_CNT) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
              match_d  = 4'd0;
              miss_d   = 3'd0;
            end else begin
              match_d = match_q + 4'd1;
            end
          end else begin
            pulse_d = 1'b1;
            match_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          // Flywheel: a corrupted input bit never enters the predictor.
          p_d = {p_q[2:0], pred};
          if (hit) begin
            miss_d = 3'd0;
          end else begin
            pulse_d = 1'b1;
            if (miss_q + 3'd1 == ERR_LIM) begin
              state_d  = ST_LOAD;
              fill_d   = 3'd0;
              locked_d = 1'b0;
              miss_d   = 3'd0;
            end else begin
              miss_d = miss_q + 3'd1;
            end
          end
        end
        default: begin
          state_d  = ST_LOAD;
          fill_d   = 3'd0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_LOAD;
      p_q      <= 4'd0;
      fill_q   <= 3'd0;
      match_q  <= 4'd0;
      miss_q   <= 3'd0;
      locked_q <= 1'b0;
      stuck_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      stuck_q  <= stuck_d;
      pulse_q  <= pulse_d;
    end
  end

`ifdef LFSR_CHK_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Clear first, then count the error of the same cycle.
  always_comb begin
    err_count_d = bus.err_clr ? 8'd0 : err_count_q;
    if (pulse_d && (err_count_d != 8'hff)) err_count_d = err_count_d + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_count_q <= 8'd0;
    else      err_count_q <= err_count_d;
  end

  assign bus.err_count = err_count_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.err_count  = 8'd0;
`endif

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = pulse_q;
  assign bus.stuck_zero = stuck_q;
  assign bus.pred_state = p_q;

endmodule
